pred_lead: RTL and testbench

Parametrised phase-lead predictor for the DRSSTC gate-drive path. It measures the half-period of the resonant feedback signal and locks onto it. Once locked, it toggles its output a programmable number of clocks before the next expected feedback edge, which compensates gate-driver and switch delay. It sits between the feedback comparator and the gate generator, and its lead value is supplied from a UART config parameter.

---
 rtl/pred_lead.sv | 148 ++++++++++++++
 tb/tb_pred_lead.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pred_lead.sv
// Phase-lead predictor: measures the resonant feedback half-period, locks onto it,
// then toggles sgn_pre a programmable number of clocks ahead of the expected edge.
module pred_lead #(
  parameter int CNT_W       = 12,
  parameter int LEAD_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HP      = 8,
  parameter int LOCK_CNT    = 4,
  parameter int TOL         = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sgn,
  input  logic [LEAD_W-1:0] lead,
  output logic              sgn_pre,
  output logic              locked,
  output logic [CNT_W-1:0]  hp_meas,
  output logic              timeout
);

  localparam int CONS_W = $clog2(LOCK_CNT + 1);
  // Compare width wide enough for hp_meas<<1 and the lead without wrapping.
  localparam int CMP_W  = ((CNT_W > LEAD_W) ? CNT_W : LEAD_W) + 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CONS_W-1:0] CONS_ONE = CONS_W'(1);
  localparam logic [CONS_W-1:0] CONS_MAX = CONS_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               sgn_s, sgn_s_d, fb_edge;
  logic [CNT_W-1:0]   cnt, hp;
  logic               cnt_sat;
  logic [CONS_W-1:0]  cons, cons_nxt, cons_inc;
  logic               pred_done, pred_done_nxt;
  logic               sgn_pre_nxt, timeout_nxt;
  logic [CMP_W-1:0]   hp_x, meas_x, diff_x, lead_x, half_x, lead_eff, pred_pt, to_pt, cnt_x;
  logic               valid, pred_hit, to_hit;

  assign sgn_s   = sync_q[SYNC_STAGES-1];
  assign fb_edge = sgn_s ^ sgn_s_d;
  assign cnt_sat = &cnt;
  assign hp      = cnt_sat ? cnt : cnt + CNT_ONE;

  assign hp_x     = CMP_W'(hp);
  assign meas_x   = CMP_W'(hp_meas);
  assign cnt_x    = CMP_W'(cnt);
  assign diff_x   = (hp_x >= meas_x) ? hp_x - meas_x : meas_x - hp_x;
  assign valid    = (hp_x >= CMP_W'(MIN_HP)) && (diff_x <= CMP_W'(TOL));
  assign lead_x   = CMP_W'(lead);
  assign half_x   = CMP_W'(hp_meas >> 1);
  assign lead_eff = (lead_x < half_x) ? lead_x : half_x;
  assign pred_pt  = meas_x - CMP_W'(1) - lead_eff;
  assign to_pt    = meas_x << 1;
  assign pred_hit = (cnt_x == pred_pt);
  assign to_hit   = (cnt_x == to_pt);
  assign cons_inc = (cons == CONS_MAX) ? cons : cons + CONS_ONE;

  assign locked = (state == LOCK);

  always_comb begin
    state_nxt     = state;
    sgn_pre_nxt   = sgn_pre;
    pred_done_nxt = pred_done;
    cons_nxt      = cons;
    timeout_nxt   = timeout;
    if (fb_edge) timeout_nxt = 1'b0;
    if (!en) begin
      state_nxt     = IDLE;
      sgn_pre_nxt   = 1'b0;
      pred_done_nxt = 1'b0;
      cons_nxt      = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt     = ACQ;
          sgn_pre_nxt   = 1'b0;
          pred_done_nxt = 1'b0;
          cons_nxt      = '0;
        end
        ACQ: begin
          sgn_pre_nxt   = sgn_s;
          pred_done_nxt = 1'b0;
          if (fb_edge) begin
            cons_nxt = valid ? cons_inc : '0;
            if (valid && (cons_inc == CONS_MAX)) state_nxt = LOCK;
          end else if (cnt_sat) begin
            timeout_nxt = 1'b1;
          end
        end
        LOCK: begin
          // The real edge always wins over a coincident predicted toggle.
          if (fb_edge) begin
            pred_done_nxt = 1'b0;
            if (!valid) begin
              state_nxt   = ACQ;
              cons_nxt    = '0;
              sgn_pre_nxt = sgn_s;
            end else begin
              cons_nxt = cons_inc;
              if (!pred_done) sgn_pre_nxt = sgn_s;
            end
          end else if (to_hit) begin
            timeout_nxt   = 1'b1;
            state_nxt     = ACQ;
            sgn_pre_nxt   = sgn_s;
            pred_done_nxt = 1'b0;
          end else if (pred_hit && !pred_done) begin
            sgn_pre_nxt   = ~sgn_s;
            pred_done_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sync_q    <= '0;
      sgn_s_d   <= 1'b0;
      cnt       <= '0;
      hp_meas   <= '0;
      cons      <= '0;
      pred_done <= 1'b0;
      sgn_pre   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], sgn};
      sgn_s_d   <= sgn_s;
      cnt       <= fb_edge ? '0 : (cnt_sat ? cnt : cnt + CNT_ONE);
      if (fb_edge && en) hp_meas <= hp;
      cons      <= cons_nxt;
      pred_done <= pred_done_nxt;
      sgn_pre   <= sgn_pre_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_pred_lead.sv
// Bench for pred_lead: square-wave feedback stimulus with a timing scoreboard
// of expected sgn_pre transition cycles plus per-scenario status checks.
module tb_pred_lead;

  localparam int CNT_W  = 12;
  localparam int LEAD_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b0;
  logic              sgn = 1'b0;
  logic [LEAD_W-1:0] lead = '0;
  logic              sgn_pre, locked, timeout;
  logic [CNT_W-1:0]  hp_meas;

  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_c;
  bit          mon_en = 1'b0;
  logic        pre_last = 1'b0;

  // Reference model of the lock state, advanced on every driven toggle.
  int last_t = 0;
  int m_hp = 0;
  int m_cons = 0;
  bit m_locked = 1'b0;

  pred_lead #(
    .CNT_W(CNT_W), .LEAD_W(LEAD_W), .SYNC_STAGES(2),
    .MIN_HP(8), .LOCK_CNT(4), .TOL(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sgn(sgn), .lead(lead),
    .sgn_pre(sgn_pre), .locked(locked), .hp_meas(hp_meas), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Advance to the next falling edge and score any sgn_pre transition.
  task automatic tick();
    @(negedge clk);
    if (mon_en && (sgn_pre !== pre_last)) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sgn_pre_timing: transition at cycle %0d, required none", cyc);
      end else begin
        exp_c = exp_q.pop_front();
        if (exp_c !== 32'(cyc))
          $display("FAIL sgn_pre_timing: transition at cycle %0d, required cycle %0d", cyc, exp_c);
        else
          n_pass++;
      end
    end
    pre_last = sgn_pre;
  endtask

  // Toggle sgn hp cycles after the previous toggle; schedule the expected sgn_pre edge.
  task automatic drive_half(input int hp);
    int le, gap, adv;
    bit valid;
    le = (int'(lead) < (m_hp >> 1)) ? int'(lead) : (m_hp >> 1);
    adv = ((m_hp - le) < hp) ? (m_hp - le) : hp;
    if (m_locked && mon_en) exp_q.push_back(32'(last_t + 3 + adv));
    tick();
    while (cyc < last_t + hp) tick();
    sgn = ~sgn;
    gap = cyc - last_t;
    if (gap > 4095) gap = 4095;
    last_t = cyc;
    if (!m_locked && mon_en) exp_q.push_back(32'(cyc + 3));
    valid = (gap >= 8) && (gap - m_hp <= 2) && (m_hp - gap <= 2);
    m_hp = gap;
    if (valid) begin
      if (m_cons < 4) m_cons++;
      if (m_cons == 4) m_locked = 1'b1;
    end else begin
      m_cons = 0;
      m_locked = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sgn = ~sgn;
      tick();
      n_total++; if (sgn_pre !== 1'b0) $display("FAIL rst_sgn_pre: got %b, required 0", sgn_pre); else n_pass++;
      n_total++; if (locked !== 1'b0) $display("FAIL rst_locked: got %b, required 0", locked); else n_pass++;
      n_total++; if (hp_meas !== '0) $display("FAIL rst_hp_meas: got %0d, required 0", hp_meas); else n_pass++;
      n_total++; if (timeout !== 1'b0) $display("FAIL rst_timeout: got %b, required 0", timeout); else n_pass++;
    end
    sgn = 1'b0;
    rst = 1'b0;
    tick();
    pre_last = sgn_pre;
    last_t = cyc;
    m_hp = 0; m_cons = 0; m_locked = 1'b0;
  endtask

  task automatic test_lock();
    lead = 8'd5;
    en = 1'b1;
    mon_en = 1'b1;
    drive_half(100);
    for (int k = 0; k < 4; k++) drive_half(20);
    n_total++; if (locked !== 1'b0) $display("FAIL lock_early: got %b, required 0", locked); else n_pass++;
    drive_half(20);
    tick(); tick();
    n_total++; if (locked !== 1'b0) $display("FAIL lock_latency: got %b, required 0", locked); else n_pass++;
    tick();
    n_total++; if (locked !== 1'b1) $display("FAIL lock_set: got %b, required 1", locked); else n_pass++;
    for (int k = 0; k < 4; k++) drive_half(20);
    n_total++; if (hp_meas !== 12'd20) $display("FAIL lock_hp_meas: got %0d, required 20", hp_meas); else n_pass++;
    n_total++; if (locked !== 1'b1) $display("FAIL lock_hold: got %b, required 1", locked); else n_pass++;
    repeat (4) tick();
    n_total++; if (exp_q.size() != 0) $display("FAIL lock_sb_drain: got %0d pending, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_lead_clamp();
    lead = 8'd15;
    for (int k = 0; k < 4; k++) drive_half(20);
    n_total++; if (locked !== 1'b1) $display("FAIL lead_clamp_locked: got %b, required 1", locked); else n_pass++;
    lead = 8'd0;
    for (int k = 0; k < 4; k++) drive_half(20);
    repeat (4) tick();
    n_total++; if (exp_q.size() != 0) $display("FAIL lead_sb_drain: got %0d pending, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_step_jitter();
    int jit [4] = '{32, 30, 28, 30};
    lead = 8'd5;
    drive_half(30);
    tick(); tick();
    n_total++; if (locked !== 1'b1) $display("FAIL step_hold: got %b, required 1", locked); else n_pass++;
    tick();
    n_total++; if (locked !== 1'b0) $display("FAIL step_drop: got %b, required 0", locked); else n_pass++;
    for (int k = 0; k < 3; k++) drive_half(30);
    n_total++; if (locked !== 1'b0) $display("FAIL relock_early: got %b, required 0", locked); else n_pass++;
    drive_half(30);
    repeat (3) tick();
    n_total++; if (locked !== 1'b1) $display("FAIL relock_set: got %b, required 1", locked); else n_pass++;
    n_total++; if (hp_meas !== 12'd30) $display("FAIL relock_hp_meas: got %0d, required 30", hp_meas); else n_pass++;
    for (int k = 0; k < 4; k++) drive_half(jit[k]);
    repeat (3) tick();
    n_total++; if (locked !== 1'b1) $display("FAIL jitter2_hold: got %b, required 1", locked); else n_pass++;
    drive_half(33);
    repeat (3) tick();
    n_total++; if (locked !== 1'b0) $display("FAIL jitter3_drop: got %b, required 0", locked); else n_pass++;
    n_total++; if (hp_meas !== 12'd33) $display("FAIL jitter3_hp_meas: got %0d, required 33", hp_meas); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL jitter_sb_drain: got %0d pending, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 5; k++) drive_half(20);
    repeat (3) tick();
    n_total++; if (locked !== 1'b1) $display("FAIL to_pre_locked: got %b, required 1", locked); else n_pass++;
    // Predicted toggle at lead 5, then the revert to pass-through when cnt hits 40.
    exp_q.push_back(32'(last_t + 3 + 20 - 5));
    exp_q.push_back(32'(last_t + 44));
    while (cyc < last_t + 43) tick();
    n_total++; if (timeout !== 1'b0) $display("FAIL to_early: got %b, required 0", timeout); else n_pass++;
    tick();
    n_total++; if (timeout !== 1'b1) $display("FAIL to_set: got %b, required 1", timeout); else n_pass++;
    n_total++; if (locked !== 1'b0) $display("FAIL to_unlock: got %b, required 0", locked); else n_pass++;
    n_total++; if (hp_meas !== 12'd20) $display("FAIL to_hp_meas: got %0d, required 20", hp_meas); else n_pass++;
    m_locked = 1'b0;
    drive_half(50);
    tick(); tick();
    n_total++; if (timeout !== 1'b1) $display("FAIL to_hold: got %b, required 1", timeout); else n_pass++;
    tick();
    n_total++; if (timeout !== 1'b0) $display("FAIL to_clear: got %b, required 0", timeout); else n_pass++;
  endtask

  task automatic test_en_rst();
    int off;
    for (int k = 0; k < 5; k++) drive_half(20);
    if (sgn !== 1'b1) drive_half(20);
    repeat (3) tick();
    n_total++; if (locked !== 1'b1) $display("FAIL en_pre_locked: got %b, required 1", locked); else n_pass++;
    n_total++; if (hp_meas !== 12'd20) $display("FAIL en_pre_hp_meas: got %0d, required 20", hp_meas); else n_pass++;
    off = $urandom_range(2, 6);
    repeat (off) tick();
    n_total++; if (exp_q.size() != 0) $display("FAIL en_sb_drain: got %0d pending, required 0", exp_q.size()); else n_pass++;
    mon_en = 1'b0;
    en = 1'b0;
    tick();
    n_total++; if (sgn_pre !== 1'b0) $display("FAIL en_off_sgn_pre: got %b, required 0", sgn_pre); else n_pass++;
    n_total++; if (locked !== 1'b0) $display("FAIL en_off_locked: got %b, required 0", locked); else n_pass++;
    n_total++; if (hp_meas !== 12'd20) $display("FAIL en_off_hp_meas: got %0d, required 20", hp_meas); else n_pass++;
    m_cons = 0;
    m_locked = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 5; k++) drive_half(20);
    if (sgn !== 1'b1) drive_half(20);
    repeat (3) tick();
    n_total++; if (locked !== 1'b1) $display("FAIL en_relock: got %b, required 1", locked); else n_pass++;
    rst = 1'b1;
    tick();
    n_total++; if (sgn_pre !== 1'b0) $display("FAIL rst_mid_sgn_pre: got %b, required 0", sgn_pre); else n_pass++;
    n_total++; if (locked !== 1'b0) $display("FAIL rst_mid_locked: got %b, required 0", locked); else n_pass++;
    n_total++; if (hp_meas !== '0) $display("FAIL rst_mid_hp_meas: got %0d, required 0", hp_meas); else n_pass++;
    n_total++; if (timeout !== 1'b0) $display("FAIL rst_mid_timeout: got %b, required 0", timeout); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_lock();
    test_lead_clamp();
    test_step_jitter();
    test_timeout();
    test_en_rst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
